itcm_fetch_rsp: RTL
===================

# itcm_fetch_rsp

Memory-side responder for the IFU instruction fetch channel. Accepts fetch requests (`ifu_req_*`), reads a single-port instruction TCM SRAM, and returns the instruction on the response channel (`ifu_rsp_*`) with full valid/ready backpressure. It sits between `ifu_ifetch` (inside `cpu_top`) and the ITCM array. It also provides a loader write port that benches and boot logic use to preload programs.

## Interface
Parameters:
- `ITCM_AW`, 14: word-address width; ITCM size is 4·2^ITCM_AW bytes.
- `ITCM_BASE`, `PC_SIZE'h0`: byte base address of the ITCM.

Ports:
- `clk`  in  1  clock; all state is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ifu_req_valid`  in  1  fetch request valid.
- `ifu_req_ready`  out  1  responder can accept a request.
- `ifu_req_pc`  in  `PC_SIZE`  fetch byte address.
- `ifu_rsp_valid`  out  1  response valid.
- `ifu_rsp_ready`  in  1  IFU accepts the response.
- `ifu_rsp_instr`  out  `INSTR_SIZE`  fetched instruction.
- `ifu_rsp_err`  out  1  fetch error. Present only with `ITCM_ERR_CHK_EN`.
- `ld_we`  in  1  loader write strobe.
- `ld_addr`  in  `ITCM_AW`  loader word address.
- `ld_wdata`  in  `INSTR_SIZE`  loader write data.

## Operation
- Word index: `widx = (ifu_req_pc - ITCM_BASE) >> 2`, truncated to `ITCM_AW` bits.
- SRAM: synchronous read. Data appears the cycle after chip-select. There is one port, shared by fetch and loader.
- Loader priority: when `ld_we`=1, the SRAM writes `ld_wdata` at `ld_addr`, and `ifu_req_ready` is forced to 0 that cycle.
- Fetch handshake: a request is accepted when `ifu_req_valid & ifu_req_ready`. A response completes when `ifu_rsp_valid & ifu_rsp_ready`.
- At most one request is in flight. The hold register covers a stalled response.

State machine states:
- IDLE:
  - `ifu_rsp_valid`=0.
  - `ifu_req_ready`=`~ld_we`.
  - On accept, go to RD.
- RD:
  - `ifu_rsp_valid`=1; `ifu_rsp_instr` is the SRAM read data, driven combinationally.
  - `ifu_req_ready`=`ifu_rsp_ready & ~ld_we`.
  - If rsp_ready and a new request is accepted, stay in RD (back-to-back).
  - If rsp_ready and no request, go to IDLE.
  - If rsp_ready=0, capture the SRAM data (and error) into the hold register and go to HOLD.
- HOLD:
  - `ifu_rsp_valid`=1; `ifu_rsp_instr`=hold register.
  - `ifu_req_ready`=`ifu_rsp_ready & ~ld_we`.
  - On rsp_ready: go to RD if a request is accepted, otherwise to IDLE.
  - The hold register is stable while in HOLD.

Other rules:
- Response ordering equals request order; no reordering or drop.
- Once `ifu_rsp_valid` is asserted, it stays high and the data stays unchanged until the handshake.
- Reset mid-operation: an in-flight or held response is discarded and the block returns to IDLE. SRAM contents are not cleared.

## Timing
- Reset values:
  - state IDLE
  - `ifu_rsp_valid`=0
  - `ifu_req_ready`=1 (with `ld_we`=0)
  - `ifu_rsp_instr`=0
  - hold register 0
  - `ifu_rsp_err`=0
- Latency: a request accepted at edge N gives a response valid in cycle N+1. It is a 1-cycle minimum.
- Throughput: 1 fetch/cycle when `ifu_rsp_ready` is held high.
- During backpressure, the SRAM is not re-read. The held data is returned exactly once.
- A simultaneous `ld_we` to the address being fetched does not corrupt an already-issued read. The response holds the pre-write data.

## Configuration
- `ITCM_ERR_CHK_EN` defined:
  - `ifu_rsp_err` exists.
  - The error condition is evaluated at request accept: `ifu_req_pc[1:0]!=0`, or `ifu_req_pc < ITCM_BASE`, or `ifu_req_pc - ITCM_BASE >= 4<<ITCM_AW`.
  - On error, the SRAM is not read, the response has `ifu_rsp_err`=1 and `ifu_rsp_instr`=0, and latency and handshake are unchanged.
- Undefined:
  - No `ifu_rsp_err` port and no range logic.
  - Out-of-range PCs alias via truncation.
  - `pc[1:0]` is ignored.

## Structure
- `PC_SIZE`, `INSTR_SIZE` and the `ITCM_ERR_CHK_EN` guard come from the shared `defines.v`.
- The state encodings (IDLE/RD/HOLD) are local.
- Sub-module `itcm_sram`: a single-port synchronous RAM with `cs`, `we`, `addr`, `wdata`, `rdata`, behavioral and depth 2^ITCM_AW. The controller instantiates it.

## Test plan
- Reset + single fetch:
  - Stimulus: load 0x00000137 at word 1, then request pc=0x4 with `ifu_rsp_ready`=1.
  - Required: `ifu_rsp_valid`=1 exactly one cycle after accept, with instr=0x00000137.
- Streaming:
  - Stimulus: words 0..3 = 0x11,0x22,0x33,0x44; pcs 0,4,8,C on consecutive cycles.
  - Required: responses 0x11,0x22,0x33,0x44 on 4 consecutive cycles, with `ifu_req_ready` high throughout.
- Backpressure:
  - Stimulus: fetch pc=0x8, hold `ifu_rsp_ready`=0 for 3 cycles, and write word 2=0xFF via the loader during the stall.
  - Required: the response stays valid with 0x33 for all 3 cycles, `ifu_req_ready`=0, and 0x33 is delivered once.
- Loader conflict:
  - Stimulus: assert `ld_we` and `ifu_req_valid` together.
  - Required: `ifu_req_ready`=0 that cycle; the request is accepted the next cycle after `ld_we` drops.
- Async reset mid-HOLD:
  - Stimulus: drop `rst_n` while in HOLD.
  - Required: `ifu_rsp_valid`=0 immediately; after release, the next fetch of pc=0x0 returns 0x11.
- With `ITCM_ERR_CHK_EN`:
  - Stimulus: pc=0x2 and pc=`ITCM_BASE`+0x10000 with `ITCM_AW`=14.
  - Required: `ifu_rsp_err`=1 and instr=0 for both; a following pc=0x0 returns err=0, 0x11.

Source files
------------

// File: rtl/itcm_fetch_rsp_pkg.sv
// Shared types and sizes for the ITCM fetch responder.
// PC_SIZE / INSTR_SIZE are local stand-ins for the values of the shared defines.
// Optional feature macro: ITCM_ERR_CHK_EN (fetch range/alignment error reporting).
package itcm_fetch_rsp_pkg;

  localparam int unsigned PC_SIZE    = 32;
  localparam int unsigned INSTR_SIZE = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/itcm_sram.sv
// Single-port synchronous ITCM array; read data appears the cycle after cs.
// rdata only changes on a read, so a write never disturbs an issued read.
module itcm_sram
  import itcm_fetch_rsp_pkg::*;
#(
  parameter int unsigned AW = 14
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [INSTR_SIZE-1:0] wdata,
  output logic [INSTR_SIZE-1:0] rdata
);

  logic [INSTR_SIZE-1:0] mem_q [2**AW];
  logic [INSTR_SIZE-1:0] rdata_q;

  // Array write or registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (cs && we) begin
      mem_q[addr] <= wdata;
    end else if (cs) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/itcm_fetch_rsp.sv
// ITCM fetch responder: accepts IFU fetches, reads the ITCM, returns instructions with
// valid/ready backpressure. Loader writes share the SRAM port and take priority.
// Optional feature macro: ITCM_ERR_CHK_EN adds ifu_rsp_err and PC range/alignment checks.
module itcm_fetch_rsp
  import itcm_fetch_rsp_pkg::*;
#(
  parameter int unsigned         ITCM_AW   = 14,
  parameter logic [PC_SIZE-1:0]  ITCM_BASE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [PC_SIZE-1:0]    ifu_req_pc,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
`ifdef ITCM_ERR_CHK_EN
  output logic                  ifu_rsp_err,
`endif
  input  logic                  ld_we,
  input  logic [ITCM_AW-1:0]    ld_addr,
  input  logic [INSTR_SIZE-1:0] ld_wdata
);

  fetch_state_e          state_q, state_d;
  logic [INSTR_SIZE-1:0] hold_q, hold_d;
  logic                  err_q, err_d;

  logic [PC_SIZE-1:0]    pc_off;
  logic [ITCM_AW-1:0]    widx;
  logic                  req_accept;
  logic                  req_err;
  logic [INSTR_SIZE-1:0] sram_rdata;
  logic [INSTR_SIZE-1:0] rd_instr;
  logic                  unused_pc_off;

  assign pc_off        = ifu_req_pc - ITCM_BASE;
  assign widx          = pc_off[ITCM_AW+1:2];
  assign unused_pc_off = ^{pc_off[1:0], pc_off[PC_SIZE-1:ITCM_AW+2]};

`ifdef ITCM_ERR_CHK_EN
  localparam logic [63:0] ItcmBytes = 64'd4 << ITCM_AW;

  assign req_err = (ifu_req_pc[1:0] != 2'b00) | (ifu_req_pc < ITCM_BASE) |
                   ({{(64-PC_SIZE){1'b0}}, pc_off} >= ItcmBytes);
  assign ifu_rsp_err = (state_q != StIdle) & err_q;
`else
  assign req_err = 1'b0;
`endif

  // A new request may enter only when the outstanding response leaves this cycle.
  assign ifu_req_ready = ~ld_we & ((state_q == StIdle) | ifu_rsp_ready);
  assign ifu_rsp_valid = (state_q != StIdle);
  assign req_accept    = ifu_req_valid & ifu_req_ready;

  // Erroring fetches never touch the array and report zero data.
  assign rd_instr = err_q ? '0 : sram_rdata;

  itcm_sram #(
    .AW(ITCM_AW)
  ) u_sram (
    .clk  (clk),
    .cs   (ld_we | (req_accept & ~req_err)),
    .we   (ld_we),
    .addr (ld_we ? ld_addr : widx),
    .wdata(ld_wdata),
    .rdata(sram_rdata)
  );

  // Next-state, hold capture and response data mux.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    err_d         = err_q;
    ifu_rsp_instr = '0;
    unique case (state_q)
      StIdle: begin
        if (req_accept) state_d = StRd;
      end
      StRd: begin
        ifu_rsp_instr = rd_instr;
        if (ifu_rsp_ready) begin
          state_d = req_accept ? StRd : StIdle;
        end else begin
          hold_d  = rd_instr;
          state_d = StHold;
        end
      end
      StHold: begin
        ifu_rsp_instr = hold_q;
        if (ifu_rsp_ready) state_d = req_accept ? StRd : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (req_accept) err_d = req_err;
  end

  // State, hold register and in-flight error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

endmodule
